// File: rtl/multilane_channel_init.sv
// Multi-lane channel bring-up sequencer: aligns, bonds and verifies the enabled lanes,
// then reports the channel ready. A watchdog restarts bring-up in any state that stalls.
package aurora_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, SP = 2'd1, I = 2'd2, VER = 2'd3} ordered_sets_e;
endpackage

module multilane_channel_init #(
  parameter int LANES     = 4,
  parameter int VER_COUNT = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      simplex_reset,
  input  logic [LANES-1:0]          lane_enable,
  input  logic [LANES-1:0]          lane_aligned,
  input  logic [LANES-1:0]          lane_bonded,
  input  logic [LANES-1:0]          lane_verified,
  output aurora_pkg::ordered_sets_e ordered_sets,
  output logic                      init_finished,
  output logic [LANES-1:0]          lane_up,
  output logic                      timeout_err,
  output logic [7:0]                retry_cnt
);
  // state        | meaning
  // ST_RESET     | idle, waiting for at least one enabled lane
  // ST_INIT      | waiting for every enabled lane to align
  // ST_BONDING   | waiting for every enabled lane to bond (multi-lane only)
  // ST_VERIFY    | counting consecutive all-verified cycles
  // ST_READY     | channel up until an enabled lane loses alignment
  typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_BONDING, ST_VERIFY, ST_READY} state_e;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e                    state_q, state_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [7:0]                ver_q, ver_d;
  logic [7:0]                retry_q, retry_d;
  logic [LANES-1:0]          en_prev_q;
  logic [LANES-1:0]          lane_up_q, lane_up_d;
  aurora_pkg::ordered_sets_e os_q, os_d;
  logic                      fin_q, fin_d;
  logic                      tmo_q;
  logic                      any_en, single_lane, all_aligned, all_bonded, all_verified;
  logic                      en_changed, counting, expire;

  assign any_en       = |lane_enable;
  assign single_lane  = any_en && ((lane_enable & (lane_enable - LANES'(1))) == '0);
  assign all_aligned  = any_en && ((lane_aligned  & lane_enable) == lane_enable);
  assign all_bonded   = any_en && ((lane_bonded   & lane_enable) == lane_enable);
  assign all_verified = any_en && ((lane_verified & lane_enable) == lane_enable);
  assign en_changed   = (state_q != ST_RESET) && (lane_enable != en_prev_q);
  assign counting     = (state_q == ST_INIT) || (state_q == ST_BONDING) || (state_q == ST_VERIFY);

  always_ff @(posedge clk) begin
    if (!rst_n || simplex_reset) begin
      state_q   <= ST_RESET;
      wd_q      <= '0;
      ver_q     <= '0;
      en_prev_q <= '0;
      os_q      <= aurora_pkg::NONE;
      fin_q     <= 1'b0;
      lane_up_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      ver_q     <= ver_d;
      en_prev_q <= lane_enable;
      os_q      <= os_d;
      fin_q     <= fin_d;
      lane_up_q <= lane_up_d;
      tmo_q     <= expire;
    end
  end

  // The retry count survives a simplex re-initialisation; only rst_n clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)              retry_q <= '0;
    else if (!simplex_reset) retry_q <= retry_d;
  end

  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      ST_RESET:   if (any_en) state_d = ST_INIT;
      ST_INIT:    if (all_aligned) state_d = single_lane ? ST_VERIFY : ST_BONDING;
      ST_BONDING: if (all_bonded) state_d = ST_VERIFY;
      ST_VERIFY:  if (all_verified && (ver_q == 8'(VER_COUNT - 1))) state_d = ST_READY;
      ST_READY:   if ((lane_enable & ~lane_aligned) != '0) state_d = ST_RESET;
      default:    state_d = ST_RESET;
    endcase
    // A genuine exit always beats a watchdog expiry landing on the same cycle.
    if (en_changed) begin
      state_d = ST_RESET;
    end else if (counting && (state_d == state_q) && (wd_q == WD_W'(TIMEOUT - 1))) begin
      state_d = ST_RESET;
      expire  = 1'b1;
    end
    wd_d  = '0;
    ver_d = '0;
    if (counting && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
    if ((state_q == ST_VERIFY) && (state_d == ST_VERIFY) && all_verified) ver_d = ver_q + 8'd1;
    retry_d = (expire && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
  end

  always_comb begin
    os_d      = aurora_pkg::NONE;
    fin_d     = 1'b0;
    lane_up_d = '0;
    case (state_q)
      ST_RESET, ST_INIT: os_d = aurora_pkg::SP;
      ST_BONDING:        os_d = aurora_pkg::I;
      ST_VERIFY:         os_d = aurora_pkg::VER;
      ST_READY: begin
        fin_d     = 1'b1;
        lane_up_d = lane_enable & lane_aligned;
      end
      default:           os_d = aurora_pkg::NONE;
    endcase
  end

  assign ordered_sets  = os_q;
  assign init_finished = fin_q;
  assign lane_up       = lane_up_q;
  assign timeout_err   = tmo_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_multilane_channel_init.sv
// Bench for multilane_channel_init: directed bring-up scenarios plus randomized traffic,
// every cycle compared against a phase-level reference model.
module tb_multilane_channel_init;
  import aurora_pkg::*;

  localparam int LANES     = 4;
  localparam int VER_COUNT = 4;
  localparam int TIMEOUT   = 15;

  logic          clk = 1'b0;
  logic          rst_n, simplex_reset;
  logic [3:0]    lane_enable, lane_aligned, lane_bonded, lane_verified;
  ordered_sets_e ordered_sets;
  logic          init_finished, timeout_err;
  logic [3:0]    lane_up;
  logic [7:0]    retry_cnt;

  int checks   = 0;
  int failures = 0;

  multilane_channel_init #(.LANES(LANES), .VER_COUNT(VER_COUNT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .simplex_reset(simplex_reset),
    .lane_enable(lane_enable), .lane_aligned(lane_aligned),
    .lane_bonded(lane_bonded), .lane_verified(lane_verified),
    .ordered_sets(ordered_sets), .init_finished(init_finished),
    .lane_up(lane_up), .timeout_err(timeout_err), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: named phase, cycles already spent in it, verified streak.
  string         m_phase = "RESET";
  int            m_dwell = 0;
  int            m_streak = 0;
  logic [3:0]    m_prev_en = '0;
  ordered_sets_e e_os = NONE;
  logic          e_fin = 1'b0;
  logic          e_terr = 1'b0;
  logic [3:0]    e_up = '0;
  int            e_retry = 0;

  function automatic bit covers(input logic [3:0] x, input logic [3:0] en);
    return (en != 4'd0) && ((x & en) == en);
  endfunction

  task automatic model_edge();
    string nxt;
    bit    expired;
    if (!rst_n || simplex_reset) begin
      m_phase = "RESET"; m_dwell = 0; m_streak = 0; m_prev_en = '0;
      e_os = NONE; e_fin = 1'b0; e_up = '0; e_terr = 1'b0;
      if (!rst_n) e_retry = 0;
      return;
    end
    if (m_phase == "BONDING")           e_os = I;
    else if (m_phase == "VERIFICATION") e_os = VER;
    else if (m_phase == "READY")        e_os = NONE;
    else                                e_os = SP;
    e_fin = (m_phase == "READY");
    e_up  = e_fin ? (lane_enable & lane_aligned) : 4'd0;
    if (m_phase == "VERIFICATION") m_streak = covers(lane_verified, lane_enable) ? m_streak + 1 : 0;
    nxt = m_phase;
    if (m_phase != "RESET" && lane_enable != m_prev_en) nxt = "RESET";
    else if (m_phase == "RESET") begin
      if (lane_enable != 4'd0) nxt = "INIT";
    end else if (m_phase == "INIT") begin
      if (covers(lane_aligned, lane_enable))
        nxt = ($countones(lane_enable) == 1) ? "VERIFICATION" : "BONDING";
    end else if (m_phase == "BONDING") begin
      if (covers(lane_bonded, lane_enable)) nxt = "VERIFICATION";
    end else if (m_phase == "VERIFICATION") begin
      if (m_streak >= VER_COUNT) nxt = "READY";
    end else if (m_phase == "READY") begin
      if ((lane_enable & ~lane_aligned) != 4'd0) nxt = "RESET";
    end
    expired = (m_phase == "INIT" || m_phase == "BONDING" || m_phase == "VERIFICATION")
              && nxt == m_phase && (m_dwell + 1 >= TIMEOUT);
    e_terr = expired;
    if (expired) begin
      nxt = "RESET";
      if (e_retry < 255) e_retry++;
    end
    if (nxt != m_phase) begin
      m_dwell = 0; m_streak = 0;
    end else begin
      m_dwell++;
    end
    m_phase   = nxt;
    m_prev_en = lane_enable;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ordered_sets",  32'(ordered_sets),  32'(e_os));
    chk("init_finished", 32'(init_finished), 32'(e_fin));
    chk("lane_up",       32'(lane_up),       32'(e_up));
    chk("timeout_err",   32'(timeout_err),   32'(e_terr));
    chk("retry_cnt",     32'(retry_cnt),     32'(e_retry));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int  n, vc, ver_os;
    bit  saw_i, saw_ver, all_sp, seen;

    rst_n = 1'b0; simplex_reset = 1'b0;
    lane_enable = '0; lane_aligned = '0; lane_bonded = '0; lane_verified = '0;
    tick(); tick();
    chk("reset_os_none", 32'(ordered_sets), 32'(NONE));
    chk("reset_retry",   32'(retry_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();

    // Full four-lane bring-up
    lane_enable = 4'hF;
    repeat (2) tick();
    lane_aligned = 4'hF;
    repeat (3) tick();
    chk("full_bonding_os", 32'(ordered_sets), 32'(I));
    lane_bonded = 4'hF;
    repeat (3) tick();
    chk("full_verify_os", 32'(ordered_sets), 32'(VER));
    lane_verified = 4'hF;
    repeat (6) tick();
    chk("full_init_finished", 32'(init_finished), 32'd1);
    chk("full_lane_up",       32'(lane_up), 32'hF);
    chk("full_ready_os",      32'(ordered_sets), 32'(NONE));

    // Alignment loss in READY
    lane_aligned = 4'b1101;
    tick(); tick();
    chk("drop_init_finished", 32'(init_finished), 32'd0);
    chk("drop_lane_up",       32'(lane_up), 32'd0);
    chk("drop_os_sp",         32'(ordered_sets), 32'(SP));

    // Single lane skips bonding
    simplex_reset = 1'b1;
    lane_enable = 4'b0100; lane_aligned = 4'b0100; lane_bonded = '0; lane_verified = '0;
    tick();
    simplex_reset = 1'b0;
    chk("single_simplex_os", 32'(ordered_sets), 32'(NONE));
    saw_i = 1'b0; saw_ver = 1'b0;
    for (int k = 0; k < 10 && !saw_ver; k++) begin
      tick();
      if (ordered_sets == I)   saw_i = 1'b1;
      if (ordered_sets == VER) saw_ver = 1'b1;
    end
    chk("single_saw_ver", 32'(saw_ver), 32'd1);
    chk("single_no_bond", 32'(saw_i), 32'd0);

    // Verified drop on the third verification cycle
    simplex_reset = 1'b1;
    lane_enable = 4'hF; lane_aligned = 4'hF; lane_bonded = 4'hF; lane_verified = '0;
    tick();
    simplex_reset = 1'b0;
    vc = 0; ver_os = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (m_phase == "VERIFICATION") begin
        vc++;
        lane_verified = (vc == 3) ? 4'h0 : 4'hF;
      end
      tick();
      if (ordered_sets == VER) ver_os++;
      if (init_finished) seen = 1'b1;
    end
    chk("reverify_ready",      32'(seen), 32'd1);
    chk("reverify_ver_cycles", 32'(ver_os), 32'd7);

    // Watchdog in INIT
    simplex_reset = 1'b1;
    lane_aligned = '0; lane_bonded = '0; lane_verified = '0;
    tick();
    simplex_reset = 1'b0;
    n = 0; seen = 1'b0; all_sp = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      n++;
      if (ordered_sets != SP) all_sp = 1'b0;
      if (timeout_err) seen = 1'b1;
    end
    chk("first_timeout_cycle", 32'(n), 32'd16);
    chk("first_timeout_retry", 32'(retry_cnt), 32'd1);
    chk("timeout_os_sp",       32'(all_sp), 32'd1);
    repeat (256 * 16 + 16) tick();
    chk("retry_saturated", 32'(retry_cnt), 32'd255);

    // simplex_reset in BONDING keeps retry_cnt
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_clears_retry", 32'(retry_cnt), 32'd0);
    for (int k = 0; k < 100 && e_retry < 3; k++) tick();
    chk("three_retries", 32'(retry_cnt), 32'd3);
    lane_aligned = 4'hF;
    repeat (3) tick();
    chk("bonding_os", 32'(ordered_sets), 32'(I));
    simplex_reset = 1'b1;
    tick();
    simplex_reset = 1'b0;
    chk("simplex_os_none", 32'(ordered_sets), 32'(NONE));
    chk("simplex_retry",   32'(retry_cnt), 32'd3);

    // lane_enable change in VERIFICATION
    lane_bonded = 4'hF;
    repeat (4) tick();
    chk("verify_os", 32'(ordered_sets), 32'(VER));
    lane_enable = 4'b0011;
    tick(); tick();
    chk("en_change_os",   32'(ordered_sets), 32'(SP));
    chk("en_change_terr", 32'(timeout_err), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(19) == 0) lane_enable = 4'($urandom);
      lane_aligned  = ($urandom_range(7) != 0) ? (lane_enable | 4'($urandom)) : 4'($urandom);
      lane_bonded   = ($urandom_range(3) != 0) ? (lane_enable | 4'($urandom)) : 4'($urandom);
      lane_verified = ($urandom_range(3) != 0) ? (lane_enable | 4'($urandom)) : 4'($urandom);
      simplex_reset = ($urandom_range(80) == 0);
      rst_n         = ($urandom_range(200) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multilane_channel_init.md
MULTILANE_CHANNEL_INIT -- requirements
Module: multilane_channel_init

Interface
REQ-001 SHALL have parameter LANES, default 4, number of lanes in the channel (1..16).
REQ-002 SHALL have parameter VER_COUNT, default 4, consecutive all-verified cycles needed to leave VERIFICATION (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1023, watchdog limit in cycles for INIT/BONDING/VERIFICATION (>=2).
REQ-004 SHALL have port clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port simplex_reset  in  1  synchronous re-initialisation request, same effect as reset except retry_cnt.
REQ-007 SHALL have port lane_enable  in  LANES  lanes participating in the channel.
REQ-008 SHALL have port lane_aligned  in  LANES  per-lane alignment status.
REQ-009 SHALL have port lane_bonded  in  LANES  per-lane bonding status.
REQ-010 SHALL have port lane_verified  in  LANES  per-lane verification status.
REQ-011 SHALL have port ordered_sets  out  aurora_pkg::ordered_sets_e  ordered set to transmit (NONE/SP/I/VER).
REQ-012 SHALL have port init_finished  out  1  channel ready.
REQ-013 SHALL have port lane_up  out  LANES  per-lane up status.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse on watchdog expiry.
REQ-015 SHALL have port retry_cnt  out  8  saturating count of watchdog expiries.

Function
REQ-016 SHALL implement states RESET, INIT, BONDING, VERIFICATION, READY.
REQ-017 "All-X" SHALL mean (X & lane_enable) == lane_enable with lane_enable != 0; single-lane SHALL mean exactly one lane_enable bit set.
REQ-018 RESET: go INIT if lane_enable != 0; otherwise remain RESET.
REQ-019 INIT: on all-aligned go VERIFICATION if single-lane, else BONDING.
REQ-020 BONDING: on all-bonded go VERIFICATION.
REQ-021 VERIFICATION: 8-bit counter increments each all-verified cycle, clears on any non-verified cycle; reaching VER_COUNT goes READY.
REQ-022 READY: if any enabled lane deasserts lane_aligned, go RESET next cycle.
REQ-023 lane_enable differing from its value last cycle, in any state other than RESET, SHALL force RESET next cycle (priority over all other transitions except reset).
REQ-024 Watchdog counter SHALL clear on every state change, count in INIT/BONDING/VERIFICATION; on reaching TIMEOUT go RESET, pulse timeout_err one cycle, increment retry_cnt saturating at 255.
REQ-025 Outputs SHALL be registered decodes of the current state (one-cycle lag): RESET/INIT->SP, BONDING->I, VERIFICATION->VER, READY->NONE.
REQ-026 init_finished SHALL be 1 the cycle after a cycle in READY, else 0.
REQ-027 lane_up SHALL register lane_enable & lane_aligned while state is READY, else 0.
REQ-028 Watchdog expiry and a simultaneous exit condition: exit condition SHALL win, no timeout_err.

Reset
REQ-029 On rst_n=0: state RESET, ordered_sets NONE, init_finished 0, lane_up 0, timeout_err 0, retry_cnt 0, all counters 0.
REQ-030 On simplex_reset=1 (rst_n=1): same as REQ-029 except retry_cnt holds its value.
REQ-031 Reset or simplex_reset mid-operation SHALL take effect on the next clock edge from any state.

Verification
REQ-032 LANES=4, enable=4'b1111, aligned/bonded/verified asserted in turn -> ordered_sets SP, I, VER, NONE; init_finished=1 after VER_COUNT=4 verified cycles; lane_up=4'b1111.
REQ-033 enable=4'b0100, aligned[2]=1 -> BONDING skipped, SP directly followed by VER.
REQ-034 verified drops on 3rd VERIFICATION cycle, then held -> READY only after 4 further consecutive cycles.
REQ-035 TIMEOUT=15, aligned never asserted -> timeout_err pulse at cycle 15 in INIT, ordered_sets stays SP, retry_cnt 1; after 256 expiries retry_cnt 255.
REQ-036 In READY, lane_aligned[1] drops -> init_finished 0 and lane_up 0 within 2 cycles, ordered_sets returns SP.
REQ-037 simplex_reset in BONDING with retry_cnt=3 -> ordered_sets NONE next cycle, retry_cnt stays 3; lane_enable change in VERIFICATION -> RESET.
